axis_sync_sample_fifo: RTL and testbench
========================================

Name: axis_sync_sample_fifo

Overview:
- Parametrised single-clock AXI4-Stream sample FIFO that buffers complex ADC samples ahead of the OSPFB input.
- Successor to the fixed-configuration vendor FIFO used between the ADC model and the OSPFB.
- Adds tlast pass-through, run-time flush, and a drop-on-full mode for sources that cannot accept backpressure.
- Adds a saturating drop counter and overflow/underflow event pulses for the event/status bus.

Parameters:
- WIDTH, 32, tdata width (complex sample = 2 x 16-bit, im in upper half, re in lower half).
- DEPTH, 16, storage depth in words; power of two, >= 4.
- PROG_EMPTY_THRESH, DEPTH/2, prog_empty asserted when count <= this value.
- PROG_FULL_THRESH, DEPTH/2, prog_full asserted when count >= this value.
- DROP_ON_FULL, 0, 0 = backpressure source when full; 1 = never backpressure, discard samples arriving when full.
- CNT_WID, 32, width of drop_count.
- COUNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of stored data.
- s_axis_tdata  in  WIDTH  write data.
- s_axis_tvalid  in  1  write valid.
- s_axis_tready  out  1  write ready.
- s_axis_tlast  in  1  write frame marker, stored with the data.
- m_axis_tdata  out  WIDTH  read data, first-word-fall-through.
- m_axis_tvalid  out  1  read valid.
- m_axis_tready  in  1  read ready.
- m_axis_tlast  out  1  tlast of the word at the head of the FIFO.
- count  out  COUNT_WIDTH  words currently stored (0..DEPTH).
- almost_empty  out  1  count == 1.
- almost_full  out  1  count == DEPTH-1.
- prog_empty  out  1  count <= PROG_EMPTY_THRESH.
- prog_full  out  1  count >= PROG_FULL_THRESH.
- event_overflow  out  1  one-cycle pulse when a sample is dropped.
- event_underflow  out  1  one-cycle pulse when m_axis_tready=1 while empty.
- drop_count  out  CNT_WID  saturating count of dropped samples.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers, count, drop_count and events go to 0; prog_empty=1; all other flags 0; m_axis_tvalid=0.
  - s_axis_tready=0 while rst is high; it follows the rules below from the first cycle after rst is released.
  - Reset mid-stream discards all stored data without emitting any event.
- Storage: circular buffer of DEPTH entries of {tlast, tdata}; read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.
- Write accepted (push) iff s_axis_tvalid && count < DEPTH && !flush && !rst.
- Read occurs (pop) iff m_axis_tvalid && m_axis_tready.
- Ready:
  - DROP_ON_FULL=0: s_axis_tready = (count < DEPTH).
  - DROP_ON_FULL=1: s_axis_tready = 1 always (outside reset).
- Drop: s_axis_tvalid && s_axis_tready && count == DEPTH.
  - A pop in the same cycle does not rescue the write; the sample is still dropped.
  - Each drop pulses event_overflow for one cycle and increments drop_count, which holds at all-ones when saturated.
- Latency: a word pushed at edge N is presented with m_axis_tvalid=1 after edge N (first-word-fall-through, 1 cycle write-to-read).
- m_axis_tvalid = (count != 0). m_axis_tdata and m_axis_tlast are taken from the read pointer and stay stable while valid and not ready.
- Count update:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - Simultaneous push and pop at count == 1 is legal: the output is the old word this cycle and the new word next cycle.
- Flags are combinational from the registered count, so they reflect the count at the start of the cycle.
- Flush: at the clk edge where flush=1, pointers and count go to 0, push and pop are suppressed, and no events fire. drop_count is not cleared.
- Underflow: event_underflow pulses in a cycle where m_axis_tready=1 and count == 0. State is unaffected.
- tlast is carried unmodified; the FIFO does not frame or repacketise.

Test Plan:
- Reset then 16 pushes with no reads (DEPTH=16, DROP_ON_FULL=0):
  - After 15 pushes almost_full=1; after 16, count=16 and s_axis_tready=0.
  - prog_full is first high at count=8.
- Fill 10 words tagged 0..9 with tlast on word 9, then drain with m_axis_tready=1: outputs are 0..9 in order with tlast only on 9, and prog_empty is high again once count <= 8.
- DROP_ON_FULL=1, fill to 16, push 5 more: s_axis_tready stays 1, event_overflow pulses 5 times, drop_count=5, and the FIFO contents are unchanged.
- Continuous push and pop at count=1 for 100 cycles: count stays 1, data emerges in order, and no events fire.
- flush asserted at count=12 together with a push: next cycle count=0, m_axis_tvalid=0, and the pushed word is lost; drop_count is retained.
- rst asserted at count=7 with m_axis_tready=1 while empty afterwards:
  - After reset all outputs are 0 except prog_empty=1.
  - event_underflow pulses every ready cycle while empty.

Source files
------------

// File: rtl/axis_sync_sample_fifo.sv
// axis_sync_sample_fifo: single-clock FWFT AXI4-Stream sample FIFO with tlast, flush,
// optional drop-on-full, saturating drop counter and overflow/underflow event pulses.
module axis_sync_sample_fifo #(
    parameter int WIDTH             = 32,
    parameter int DEPTH             = 16,
    parameter int PROG_EMPTY_THRESH = DEPTH/2,
    parameter int PROG_FULL_THRESH  = DEPTH/2,
    parameter int DROP_ON_FULL      = 0,
    parameter int CNT_WID           = 32,
    parameter int COUNT_WIDTH       = $clog2(DEPTH)+1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [WIDTH-1:0]       m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic                   prog_empty,
    output logic                   prog_full,
    output logic                   event_overflow,
    output logic                   event_underflow,
    output logic [CNT_WID-1:0]     drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] PE_TH = COUNT_WIDTH'(PROG_EMPTY_THRESH);
    localparam logic [COUNT_WIDTH-1:0] PF_TH = COUNT_WIDTH'(PROG_FULL_THRESH);

    logic [WIDTH:0]  mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop, drop;

    assign s_axis_tready = !rst && (DROP_ON_FULL != 0 || count < FULL);
    assign push          = s_axis_tvalid && count < FULL && !flush && !rst;
    assign pop           = m_axis_tvalid && m_axis_tready;
    // A concurrent pop never frees room for a write that arrives while full.
    assign drop          = s_axis_tvalid && s_axis_tready && count == FULL;

    assign m_axis_tvalid              = count != '0;
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];
    assign almost_empty = count == COUNT_WIDTH'(1);
    assign almost_full  = count == FULL - COUNT_WIDTH'(1);
    assign prog_empty   = count <= PE_TH;
    assign prog_full    = count >= PF_TH;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            event_overflow  <= 1'b0;
            event_underflow <= 1'b0;
            if (rst) drop_count <= '0;
        end else begin
            wr_ptr          <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr          <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count           <= (push && !pop) ? count + COUNT_WIDTH'(1) :
                               (pop && !push) ? count - COUNT_WIDTH'(1) : count;
            event_overflow  <= drop;
            event_underflow <= m_axis_tready && count == '0;
            drop_count      <= (drop && !(&drop_count)) ? drop_count + CNT_WID'(1) : drop_count;
        end
    end
endmodule

// File: tb/tb_axis_sync_sample_fifo.sv
// tb_axis_sync_sample_fifo: three FIFO variants on shared stimulus, checked every cycle
// against a queue-based model, plus directed scenarios with literal expectations.
module tb_axis_sync_sample_fifo;
    logic clk = 0;
    always #5 clk = ~clk;

    logic        rst = 1, flush = 0, s_tvalid = 0, s_tlast = 0, m_tready = 0;
    logic [31:0] s_tdata = 0;
    logic [31:0] m_tdata [3];
    logic        m_tvalid [3], m_tlast [3], s_tready [3];
    logic        ae [3], af [3], pe [3], pf [3], ov [3], un [3];
    logic [4:0]  cnt [3];
    logic [31:0] dcnt [2];
    logic [2:0]  dcnt2;

    axis_sync_sample_fifo #(.DROP_ON_FULL(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata[0]),
        .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[0]),
        .count(cnt[0]), .almost_empty(ae[0]), .almost_full(af[0]), .prog_empty(pe[0]),
        .prog_full(pf[0]), .event_overflow(ov[0]), .event_underflow(un[0]), .drop_count(dcnt[0]));

    axis_sync_sample_fifo #(.DROP_ON_FULL(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata[1]),
        .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[1]),
        .count(cnt[1]), .almost_empty(ae[1]), .almost_full(af[1]), .prog_empty(pe[1]),
        .prog_full(pf[1]), .event_overflow(ov[1]), .event_underflow(un[1]), .drop_count(dcnt[1]));

    axis_sync_sample_fifo #(.DROP_ON_FULL(1), .CNT_WID(3), .PROG_EMPTY_THRESH(3), .PROG_FULL_THRESH(13)) u2 (
        .clk(clk), .rst(rst), .flush(flush), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready[2]), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata[2]),
        .m_axis_tvalid(m_tvalid[2]), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast[2]),
        .count(cnt[2]), .almost_empty(ae[2]), .almost_full(af[2]), .prog_empty(pe[2]),
        .prog_full(pf[2]), .event_overflow(ov[2]), .event_underflow(un[2]), .drop_count(dcnt2));

    int              tests = 0, fails = 0;
    bit              chk_en = 0;
    int              mode [3] = '{0, 1, 1};
    int              pet [3]  = '{8, 8, 3};
    int              pft [3]  = '{8, 8, 13};
    longint unsigned dmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};

    logic [32:0]     mq [3][$];
    longint unsigned mdc [3];
    bit              mov [3], mun [3];
    int              mn, cn;
    logic [32:0]     hd;

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Reference model: stored words as a queue, events/counter from the input rules.
    always @(posedge clk)
        for (int i = 0; i < 3; i++) begin
            mn = mq[i].size();
            if (rst) begin
                mq[i].delete(); mdc[i] = 0; mov[i] = 0; mun[i] = 0;
            end else if (flush) begin
                mq[i].delete(); mov[i] = 0; mun[i] = 0;
            end else begin
                mov[i] = s_tvalid && mode[i] == 1 && mn == 16;
                mun[i] = m_tready && mn == 0;
                if (m_tready && mn > 0) void'(mq[i].pop_front());
                if (s_tvalid && mn < 16) mq[i].push_back({s_tlast, s_tdata});
                if (mov[i] && mdc[i] < dmax[i]) mdc[i]++;
            end
        end

    always @(posedge clk) begin
        #1;
        if (chk_en)
            for (int i = 0; i < 3; i++) begin
                cn = mq[i].size();
                chk("count", i, cnt[i], cn);
                chk("m_tvalid", i, m_tvalid[i], cn != 0);
                chk("s_tready", i, s_tready[i], !rst && (mode[i] == 1 || cn < 16));
                chk("almost_empty", i, ae[i], cn == 1);
                chk("almost_full", i, af[i], cn == 15);
                chk("prog_empty", i, pe[i], cn <= pet[i]);
                chk("prog_full", i, pf[i], cn >= pft[i]);
                chk("ev_overflow", i, ov[i], mov[i]);
                chk("ev_underflow", i, un[i], mun[i]);
                chk("drop_count", i, i == 2 ? 32'(dcnt2) : dcnt[i], mdc[i]);
                if (cn > 0) begin
                    hd = mq[i][0];
                    chk("m_tdata", i, m_tdata[i], hd[31:0]);
                    chk("m_tlast", i, m_tlast[i], hd[32]);
                end
            end
    end

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic r,
                        input logic f, input logic rs);
        s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r; flush = f; rst = rs;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (3) step(0, 0, 0, 0, 0, 1);
        chk_en = 1;
        chk("rst_count", 0, cnt[0], 0);
        chk("rst_prog_empty", 0, pe[0], 1);
        chk("rst_tready", 1, s_tready[1], 0);
        chk("rst_tvalid", 0, m_tvalid[0], 0);
        for (int k = 0; k < 16; k++) begin
            step(1, k, 0, 0, 0, 0);
            if (k == 6) chk("pf_at7", 0, pf[0], 0);
            if (k == 7) chk("pf_at8", 0, pf[0], 1);
            if (k == 14) chk("af_at15", 0, af[0], 1);
        end
        chk("full_count", 0, cnt[0], 16);
        chk("full_tready", 0, s_tready[0], 0);
        chk("full_tready_drop", 1, s_tready[1], 1);
        for (int k = 0; k < 5; k++) begin
            step(1, 100 + k, 0, 0, 0, 0);
            chk("drop_pulse", 1, ov[1], 1);
        end
        chk("drop_cnt5", 1, dcnt[1], 5);
        chk("drop_cnt5_sat", 2, 32'(dcnt2), 5);
        chk("drop_cnt_bp", 0, dcnt[0], 0);
        chk("drop_head", 1, m_tdata[1], 0);
        step(0, 0, 0, 0, 0, 0);
        chk("drop_pulse_end", 1, ov[1], 0);

        step(0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 12; k++) step(1, 200 + k, 0, 0, 0, 0);
        step(1, 999, 0, 0, 1, 0);
        chk("flush_count", 0, cnt[0], 0);
        chk("flush_tvalid", 0, m_tvalid[0], 0);
        chk("flush_keep_drops", 1, dcnt[1], 5);
        step(0, 0, 0, 0, 0, 0);
        chk("flush_lost", 0, cnt[0], 0);

        for (int k = 0; k < 10; k++) step(1, k, k == 9, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            chk("drain_data", 0, m_tdata[0], k);
            chk("drain_last", 0, m_tlast[0], k == 9);
            chk("drain_pe", 0, pe[0], (10 - k) <= 8);
            step(0, 0, 0, 1, 0, 0);
        end
        chk("drain_empty", 0, cnt[0], 0);

        step(1, 500, 0, 0, 0, 0);
        for (int k = 1; k <= 100; k++) begin
            step(1, 500 + k, 0, 1, 0, 0);
            chk("stream_count", 0, cnt[0], 1);
            chk("stream_data", 0, m_tdata[0], 500 + k);
        end
        step(0, 0, 0, 1, 0, 0);

        for (int k = 0; k < 7; k++) step(1, k, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("rst7_count", 0, cnt[0], 0);
        chk("rst7_tvalid", 0, m_tvalid[0], 0);
        chk("rst7_pe", 0, pe[0], 1);
        chk("rst7_un", 0, un[0], 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0, 0);
            chk("underflow", 0, un[0], 1);
        end

        for (int k = 0; k < 3000; k++) begin
            int pv, pr;
            pv = (k / 500) % 3 == 0 ? 90 : (k / 500) % 3 == 1 ? 50 : 15;
            pr = (k / 500) % 3 == 0 ? 15 : (k / 500) % 3 == 1 ? 50 : 90;
            step($urandom_range(0, 99) < pv, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < pr, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 599) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
